// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard bus: decode-side request fields in, pipeline control out.
interface hazard_scoreboard_if #(
    parameter int REG_W = 4,
    parameter int DEPTH = 3,
    parameter int CNT_W = 16
);
    localparam int FS_W = $clog2(DEPTH + 1);

    logic             id_valid;
    logic [REG_W-1:0] id_src1;
    logic [REG_W-1:0] id_src2;
    logic             id_two_src;
    logic             id_wb_en;
    logic             id_mem_r_en;
    logic [REG_W-1:0] id_dest;
    logic             branch_taken;
    logic             freeze;
    logic             flush;
    logic [FS_W-1:0]  fwd_sel1;
    logic [FS_W-1:0]  fwd_sel2;
    logic [CNT_W-1:0] stall_count;

    // pipeline / decode side
    modport master (
        output id_valid, id_src1, id_src2, id_two_src, id_wb_en,
               id_mem_r_en, id_dest, branch_taken,
        input  freeze, flush, fwd_sel1, fwd_sel2, stall_count
    );

    // scoreboard side
    modport slave (
        input  id_valid, id_src1, id_src2, id_two_src, id_wb_en,
               id_mem_r_en, id_dest, branch_taken,
        output freeze, flush, fwd_sel1, fwd_sel2, stall_count
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: tracks in-flight destination writes behind ID and
// produces freeze / flush / forwarding selects plus a stall counter.

// Per-slot source compare against one in-flight destination.
module hazard_scoreboard_cmp #(
    parameter int REG_W = 4
) (
    input  logic             i_live,
    input  logic [REG_W-1:0] i_dst,
    input  logic [REG_W-1:0] i_src1,
    input  logic [REG_W-1:0] i_src2,
    input  logic             i_two_src,
    output logic             o_m1,
    output logic             o_m2
);
    assign o_m1 = i_live & (i_dst == i_src1);
    assign o_m2 = i_live & i_two_src & (i_dst == i_src2);
endmodule

module hazard_scoreboard #(
    parameter int REG_W  = 4,
    parameter int DEPTH  = 3,
    parameter int FWD_EN = 0,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    hazard_scoreboard_if.slave  bus
);
    localparam int FS_W = $clog2(DEPTH + 1);

    // Load flag is only ever consulted at slot 0, so it is kept beside the
    // shift register instead of travelling with every entry.
    typedef struct packed {
        logic             v;
        logic             wb;
        logic [REG_W-1:0] dst;
    } slot_t;

    slot_t [DEPTH-1:0] r_slot;
    logic              r_ld0;
    logic [CNT_W-1:0]  r_cnt;

    logic [DEPTH-1:0]  w_m1;
    logic [DEPTH-1:0]  w_m2;
    logic [FS_W-1:0]   w_sel1;
    logic [FS_W-1:0]   w_sel2;
    logic              w_hz_any;
    logic              w_load_use;
    logic              w_freeze;
    logic              w_issue;

    for (genvar k = 0; k < DEPTH; k++) begin : g_cmp
        hazard_scoreboard_cmp #(.REG_W(REG_W)) u_cmp (
            .i_live    (bus.id_valid & r_slot[k].v & r_slot[k].wb),
            .i_dst     (r_slot[k].dst),
            .i_src1    (bus.id_src1),
            .i_src2    (bus.id_src2),
            .i_two_src (bus.id_two_src),
            .o_m1      (w_m1[k]),
            .o_m2      (w_m2[k])
        );
    end

    assign w_hz_any   = |(w_m1 | w_m2);
    assign w_load_use = (w_m1[0] | w_m2[0]) & r_ld0;
    // A taken branch kills the ID instruction, so it can never be frozen.
    assign w_freeze   = ((FWD_EN != 0) ? w_load_use : w_hz_any) & ~bus.branch_taken;
    assign w_issue    = bus.id_valid & ~w_freeze & ~bus.branch_taken;

    // Lowest matching slot wins: scan oldest to youngest so the youngest
    // producer overwrites.
    always_comb begin
        w_sel1 = '0;
        w_sel2 = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (w_m1[k]) w_sel1 = FS_W'(k + 1);
            if (w_m2[k]) w_sel2 = FS_W'(k + 1);
        end
    end

    assign bus.freeze      = w_freeze;
    assign bus.flush       = bus.branch_taken;
    assign bus.fwd_sel1    = ((FWD_EN != 0) && !w_freeze) ? w_sel1 : '0;
    assign bus.fwd_sel2    = ((FWD_EN != 0) && !w_freeze) ? w_sel2 : '0;
    assign bus.stall_count = r_cnt;

    // Scoreboard shift: downstream slots always drain, slot 0 takes ID or a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_slot <= '0;
            r_ld0  <= 1'b0;
        end else begin
            r_slot[0] <= w_issue ? slot_t'{v: 1'b1, wb: bus.id_wb_en, dst: bus.id_dest}
                                 : slot_t'('0);
            r_ld0     <= w_issue & bus.id_mem_r_en;
            for (int k = 1; k < DEPTH; k++) begin
                r_slot[k] <= r_slot[k-1];
            end
        end
    end

    // Saturating count of frozen cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_freeze && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: DUT A = stall-only (CNT_W=4), DUT B = forwarding.
module tb_hazard_scoreboard;
    typedef struct packed {
        logic       v;
        logic [3:0] s1;
        logic [3:0] s2;
        logic       two;
        logic       wb;
        logic       ld;
        logic [3:0] dst;
        logic       br;
    } in_t;

    typedef struct packed {
        logic       v;
        logic       wb;
        logic       ld;
        logic [3:0] dst;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    in_t  ina = '0;
    in_t  inb = '0;

    int   nchk = 0;
    int   npass = 0;

    // Model: every edge records what was issued, indexed by edge number.
    // Slot k in the current cycle is whatever was issued k+1 edges ago.
    ent_t iss [2][4096];
    int   cyc = 0;
    int   rst_cyc = 0;
    int   cnt_a = 0;
    int   cnt_b = 0;

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.REG_W(4), .DEPTH(3), .CNT_W(4))  ifa ();
    hazard_scoreboard_if #(.REG_W(4), .DEPTH(3), .CNT_W(16)) ifb ();

    assign ifa.id_valid = ina.v;   assign ifb.id_valid = inb.v;
    assign ifa.id_src1 = ina.s1;   assign ifb.id_src1 = inb.s1;
    assign ifa.id_src2 = ina.s2;   assign ifb.id_src2 = inb.s2;
    assign ifa.id_two_src = ina.two;   assign ifb.id_two_src = inb.two;
    assign ifa.id_wb_en = ina.wb;  assign ifb.id_wb_en = inb.wb;
    assign ifa.id_mem_r_en = ina.ld;   assign ifb.id_mem_r_en = inb.ld;
    assign ifa.id_dest = ina.dst;  assign ifb.id_dest = inb.dst;
    assign ifa.branch_taken = ina.br;  assign ifb.branch_taken = inb.br;

    hazard_scoreboard #(.REG_W(4), .DEPTH(3), .FWD_EN(0), .CNT_W(4)) dut_a (
        .clk (clk), .rst (rst), .bus (ifa)
    );
    hazard_scoreboard #(.REG_W(4), .DEPTH(3), .FWD_EN(1), .CNT_W(16)) dut_b (
        .clk (clk), .rst (rst), .bus (ifb)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // Expected freeze / selects for DUT w (0 = stall-only, 1 = forwarding).
    function automatic void exp_out(input int w, input in_t x,
                                    output logic fz, output logic [1:0] f1, output logic [1:0] f2);
        int   idx;
        ent_t e;
        logic h1, h2, any, lu;
        f1 = 0; f2 = 0; any = 0; lu = 0;
        for (int age = 2; age >= 0; age--) begin
            idx = cyc - 1 - age;
            if (idx >= 0 && idx >= rst_cyc) begin
                e  = iss[w][idx % 4096];
                h1 = x.v && e.v && e.wb && (e.dst == x.s1);
                h2 = x.v && x.two && e.v && e.wb && (e.dst == x.s2);
                if (h1) f1 = 2'(age + 1);
                if (h2) f2 = 2'(age + 1);
                if (h1 || h2) any = 1;
                if (age == 0 && (h1 || h2) && e.ld) lu = 1;
            end
        end
        fz = (w == 0 ? any : lu) && !x.br;
        if (w == 0 || fz) begin f1 = 0; f2 = 0; end
    endfunction

    // Model state advance.
    always @(posedge clk or negedge rst) begin
        logic fza, fzb;
        logic [1:0] a1, a2, b1, b2;
        if (!rst) begin
            rst_cyc <= cyc;
            cnt_a   <= 0;
            cnt_b   <= 0;
        end else begin
            exp_out(0, ina, fza, a1, a2);
            exp_out(1, inb, fzb, b1, b2);
            iss[0][cyc % 4096] <= (ina.v && !fza && !ina.br) ? ent_t'{1'b1, ina.wb, ina.ld, ina.dst} : ent_t'('0);
            iss[1][cyc % 4096] <= (inb.v && !fzb && !inb.br) ? ent_t'{1'b1, inb.wb, inb.ld, inb.dst} : ent_t'('0);
            if (fza && cnt_a < 15)    cnt_a <= cnt_a + 1;
            if (fzb && cnt_b < 65535) cnt_b <= cnt_b + 1;
            cyc <= cyc + 1;
        end
    end

    // Every-cycle compare against the model.
    always @(negedge clk) begin
        logic fz;
        logic [1:0] s1, s2;
        exp_out(0, ina, fz, s1, s2);
        chk("A.freeze", 32'(ifa.freeze), 32'(fz));
        chk("A.flush",  32'(ifa.flush), 32'(ina.br));
        chk("A.fwd1",   32'(ifa.fwd_sel1), 32'(s1));
        chk("A.fwd2",   32'(ifa.fwd_sel2), 32'(s2));
        chk("A.stall",  32'(ifa.stall_count), 32'(cnt_a));
        exp_out(1, inb, fz, s1, s2);
        chk("B.freeze", 32'(ifb.freeze), 32'(fz));
        chk("B.flush",  32'(ifb.flush), 32'(inb.br));
        chk("B.fwd1",   32'(ifb.fwd_sel1), 32'(s1));
        chk("B.fwd2",   32'(ifb.fwd_sel2), 32'(s2));
        chk("B.stall",  32'(ifb.stall_count), 32'(cnt_b));
    end

    function automatic in_t mk(input logic [3:0] s1, input logic [3:0] s2, input logic two,
                               input logic wb, input logic ld, input logic [3:0] dst);
        in_t r;
        r = '0;
        r.v = 1; r.s1 = s1; r.s2 = s2; r.two = two; r.wb = wb; r.ld = ld; r.dst = dst;
        return r;
    endfunction

    function automatic in_t rnd();
        in_t r;
        r.v   = ($urandom_range(0, 3) != 0);
        r.s1  = 4'($urandom_range(0, 3));
        r.s2  = 4'($urandom_range(0, 3));
        r.two = 1'($urandom_range(0, 1));
        r.wb  = ($urandom_range(0, 3) != 0);
        r.ld  = ($urandom_range(0, 2) == 0);
        r.dst = 4'($urandom_range(0, 3));
        r.br  = ($urandom_range(0, 7) == 0);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with arbitrary inputs.
        ina = rnd(); inb = rnd();
        ina.v = 1; ina.wb = 1; ina.s1 = ina.dst;
        repeat (2) @(posedge clk);
        #2;
        chk("rst.freezeA", 32'(ifa.freeze), 0);
        chk("rst.fwdB",    32'(ifb.fwd_sel1), 0);
        chk("rst.stallA",  32'(ifa.stall_count), 0);
        chk("rst.flushA",  32'(ifa.flush), 32'(ina.br));
        ina = '0; inb = '0;
        #1 rst = 1;

        // Stall-only back-to-back dependence: 3 frozen cycles.
        step(); ina = mk(3, 4, 1, 1, 0, 1);
        step(); ina = mk(1, 5, 1, 1, 0, 6); #1 chk("raw.c1", 32'(ifa.freeze), 1);
        step(); #1 chk("raw.c2", 32'(ifa.freeze), 1);
        step(); #1 chk("raw.c3", 32'(ifa.freeze), 1);
        step(); #1 chk("raw.c4", 32'(ifa.freeze), 0);
        chk("raw.stall", 32'(ifa.stall_count), 3);
        step(); ina = '0;

        // Branch with hazard: flush wins, instruction not inserted.
        step(); ina = mk(3, 4, 1, 1, 0, 1);
        step(); ina = mk(1, 5, 1, 1, 0, 6); ina.br = 1;
        #1 chk("br.flush", 32'(ifa.flush), 1);
        chk("br.freeze", 32'(ifa.freeze), 0);
        step(); ina = mk(6, 6, 1, 1, 0, 7);
        #1 chk("br.nomatch", 32'(ifa.freeze), 0);
        chk("br.stall", 32'(ifa.stall_count), 3);
        step(); ina = '0;
        repeat (3) step();

        // Saturation of the 4-bit counter.
        repeat (7) begin
            step(); ina = mk(3, 4, 1, 1, 0, 1);
            step(); ina = mk(1, 5, 1, 1, 0, 6);
            repeat (3) step();
        end
        step(); ina = '0;
        #1 chk("sat.stall", 32'(ifa.stall_count), 15);

        // Reset mid-stall drops freeze without an edge.
        step(); ina = mk(3, 4, 1, 1, 0, 1);
        step(); ina = mk(1, 5, 1, 1, 0, 6); #1 chk("mid.c1", 32'(ifa.freeze), 1);
        step(); #1 chk("mid.c2", 32'(ifa.freeze), 1);
        #1 rst = 0;
        #1 chk("mid.freeze", 32'(ifa.freeze), 0);
        chk("mid.stall", 32'(ifa.stall_count), 0);
        step(); rst = 1; ina = '0;

        // Forwarding selects.
        step(); inb = mk(3, 4, 1, 1, 0, 1);
        step(); inb = mk(1, 5, 1, 1, 0, 6);
        #1 chk("fw.freeze", 32'(ifb.freeze), 0);
        chk("fw.sel1", 32'(ifb.fwd_sel1), 1);
        step(); inb = mk(7, 8, 1, 1, 0, 2);
        step(); inb = mk(10, 11, 1, 1, 0, 9);
        step(); inb = mk(2, 13, 1, 1, 0, 12);
        #1 chk("fw.gap", 32'(ifb.fwd_sel1), 2);
        step(); inb = mk(9, 2, 1, 1, 0, 14);
        #1 chk("fw.both1", 32'(ifb.fwd_sel1), 2);
        chk("fw.both2", 32'(ifb.fwd_sel2), 3);

        // Load-use.
        step(); inb = mk(13, 14, 0, 1, 1, 3);
        step(); inb = mk(5, 3, 1, 1, 0, 4);
        #1 chk("lu.freeze", 32'(ifb.freeze), 1);
        chk("lu.sel0", 32'(ifb.fwd_sel2), 0);
        step(); #1 chk("lu.after", 32'(ifb.freeze), 0);
        chk("lu.sel2", 32'(ifb.fwd_sel2), 2);
        chk("lu.stall", 32'(ifb.stall_count), 1);
        step(); inb = mk(13, 14, 0, 1, 1, 3);
        step(); inb = mk(5, 3, 0, 1, 0, 4);
        #1 chk("lu.onesrc", 32'(ifb.freeze), 0);
        chk("lu.onesrc2", 32'(ifb.fwd_sel2), 0);
        step(); inb = '0;

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 800; i++) begin
            step();
            ina = rnd();
            inb = rnd();
            rst = ($urandom_range(0, 99) != 0);
        end
        step(); rst = 1; ina = '0; inb = '0;
        step();

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
